// File: rtl/multi_digit_scan_driver_if.sv
// Bundle between the datapath and the seven-segment scan driver.
// Datapath-side values in, board-pin drive out.
interface multi_digit_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  // There is no valid/ready pair. The datapath holds its values level-stable.
  // The driver copies them into its snapshot on a frame boundary and flags
  // that copy with a one-cycle frame_start. It samples bright at every slot start.
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dec_pts;
  logic [N_DIGITS-1:0]   signs;
  logic [N_DIGITS-1:0]   blink;
  logic [3:0]            bright;
  logic                  lz_blank;
  logic [6:0]            segs;
  logic                  DP;
  logic [N_DIGITS-1:0]   anodes;
  logic                  frame_start;

  modport master (
    output digits, dec_pts, signs, blink, bright, lz_blank,
    input  segs, DP, anodes, frame_start
  );

  modport slave (
    input  digits, dec_pts, signs, blink, bright, lz_blank,
    output segs, DP, anodes, frame_start
  );
endinterface

// File: rtl/multi_digit_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame snapshots,
// blink, 16-level brightness, leading-zero blanking and a dark guard cycle per slot.
module multi_digit_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 10000,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  multi_digit_scan_driver_if.slave   bus
);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int FC_W   = $clog2(BLINK_FRAMES + 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic [3:0]            bright_q;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_signs;
  logic [N_DIGITS-1:0]   snap_blink;
  logic                  snap_lz;

  logic [6:0]            segs_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   anodes_q;
  logic                  frame_start_q;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [31:0]           on_cycles;
  logic [3:0]            cur_nib;
  logic                  lead_blank;
  logic                  dark;
  logic [6:0]            segs_nxt;
  logic                  dp_nxt;
  logic [N_DIGITS-1:0]   anodes_nxt;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign slot_wrap  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign frame_wrap = slot_wrap && (idx == IDX_W'(N_DIGITS - 1));
  assign on_cycles  = (32'(bright_q) + 32'd1) * 32'(SCAN_DIV / 16);

  always_comb begin
    cur_nib    = snap_digits[{idx, 2'b00} +: 4];
    lead_blank = snap_lz && (idx != '0);
    // A digit is leading only if it and everything to its left is fully empty.
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(idx)) begin
        if ((snap_digits[4*j +: 4] != 4'h0) || snap_signs[j] || snap_dp[j]) begin
          lead_blank = 1'b0;
        end
      end
    end
    dark = (slot_cnt == '0) || (32'(slot_cnt) >= on_cycles) ||
           (snap_blink[idx] && !blink_phase) || lead_blank;
    segs_nxt   = 7'h7F;
    dp_nxt     = 1'b1;
    anodes_nxt = '1;
    if (!dark) begin
      segs_nxt        = snap_signs[idx] ? 7'b0111111 : hex_to_segs(cur_nib);
      dp_nxt          = ~snap_dp[idx];
      anodes_nxt[idx] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt      <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      blink_phase   <= 1'b1;
      bright_q      <= 4'hF;
      snap_digits   <= '0;
      snap_dp       <= '0;
      snap_signs    <= '0;
      snap_blink    <= '0;
      snap_lz       <= 1'b0;
      segs_q        <= 7'h7F;
      dp_q          <= 1'b1;
      anodes_q      <= '1;
      frame_start_q <= 1'b0;
    end else begin
      segs_q        <= segs_nxt;
      dp_q          <= dp_nxt;
      anodes_q      <= anodes_nxt;
      frame_start_q <= frame_wrap;
      // The guard cycle is always dark, so sampling here never changes a lit slot.
      if (slot_cnt == '0) begin
        bright_q <= bus.bright;
      end
      if (slot_wrap) begin
        slot_cnt <= '0;
        idx      <= frame_wrap ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_wrap) begin
        snap_digits <= bus.digits;
        snap_dp     <= bus.dec_pts;
        snap_signs  <= bus.signs;
        snap_blink  <= bus.blink;
        snap_lz     <= bus.lz_blank;
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.segs        = segs_q;
  assign bus.DP          = dp_q;
  assign bus.anodes      = anodes_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_multi_digit_scan_driver.sv
// Directed bench for multi_digit_scan_driver: table of frame vectors plus
// hand-written reset, mid-frame change, blink and mid-frame reset sequences.
module tb_multi_digit_scan_driver;
  localparam int N  = 4;
  localparam int SD = 16;
  localparam int FRAME = N * SD;

  logic CLK;
  logic RST_N;
  int   checks = 0;
  int   passes = 0;

  multi_digit_scan_driver_if #(.N_DIGITS(N)) bus ();

  multi_digit_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dec_pts;
    logic [3:0]      signs;
    logic [3:0]      bright;
    logic            lz;
    logic [3:0][6:0] exp_segs;
    logic [3:0]      exp_dp;
    logic [3:0][4:0] exp_lit;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] sg,
                       input logic [3:0] bl, input logic [3:0] br, input logic lz);
    bus.digits   = dg;
    bus.dec_pts  = dp;
    bus.signs    = sg;
    bus.blink    = bl;
    bus.bright   = br;
    bus.lz_blank = lz;
  endtask

  task automatic wait_frame_start(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 3 * FRAME && !seen; k++) begin
      @(negedge CLK);
      if (bus.frame_start) seen = 1'b1;
    end
    chk({name, "_frame_start"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic observe_frame(output logic [3:0][4:0] lit, output logic [3:0][6:0] sg,
                               output logic [3:0] dp, output int bad);
    int nlow;
    int ld;
    lit = '0; sg = '1; dp = '1; bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge CLK);
      nlow = 0; ld = 0;
      for (int d = 0; d < N; d++) begin
        if (!bus.anodes[d]) begin nlow++; ld = d; end
      end
      if (nlow == 0) begin
        if (bus.segs !== 7'h7F || bus.DP !== 1'b1) bad++;
      end else if (nlow > 1) begin
        bad++;
      end else begin
        if (lit[ld] == 0) begin
          sg[ld] = bus.segs;
          dp[ld] = bus.DP;
        end else if (sg[ld] !== bus.segs || dp[ld] !== bus.DP) begin
          bad++;
        end
        lit[ld] = lit[ld] + 5'd1;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [3:0][6:0] es,
                             input logic [3:0] edp, input logic [3:0][4:0] elit);
    logic [3:0][4:0] lit;
    logic [3:0][6:0] sg;
    logic [3:0]      dp;
    int              bad;
    observe_frame(lit, sg, dp, bad);
    chk({name, "_dark_onehot"}, 32'(bad), 32'd0);
    for (int d = 0; d < N; d++) begin
      chk($sformatf("%s_lit%0d", name, d), 32'(lit[d]), 32'(elit[d]));
      if (elit[d] != 0) begin
        chk($sformatf("%s_segs%0d", name, d), 32'(sg[d]), 32'(es[d]));
        chk($sformatf("%s_dp%0d", name, d), 32'(dp[d]), 32'(edp[d]));
      end
    end
  endtask

  initial begin
    logic [3:0] prev_an;
    int ldig;
    logic [15:0] ev;

    vecs[0] = '{16'h12AF, 4'b0001, 4'b0100, 4'hF, 1'b0, {7'h79, 7'h3F, 7'h08, 7'h0E}, 4'b1110, {5'd15, 5'd15, 5'd15, 5'd15}};
    vecs[1] = '{16'h3456, 4'b0000, 4'b0000, 4'h3, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1111, {5'd3, 5'd3, 5'd3, 5'd3}};
    vecs[2] = '{16'h3456, 4'b0000, 4'b0000, 4'h0, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd0}};
    vecs[3] = '{16'h0050, 4'b0000, 4'b0000, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, {5'd0, 5'd0, 5'd15, 5'd15}};
    vecs[4] = '{16'h0000, 4'b0000, 4'b0000, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd15}};
    vecs[5] = '{16'h0000, 4'b1000, 4'b0000, 4'hF, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0111, {5'd15, 5'd15, 5'd15, 5'd15}};
    vecs[6] = '{16'h0000, 4'b0000, 4'b0100, 4'hF, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h40}, 4'b1111, {5'd0, 5'd15, 5'd15, 5'd15}};
    vecs[7] = '{16'hEDC8, 4'b0110, 4'b1000, 4'h7, 1'b0, {7'h3F, 7'h21, 7'h46, 7'h00}, 4'b1001, {5'd7, 5'd7, 5'd7, 5'd7}};
    vecs[8] = '{16'h09B0, 4'b0000, 4'b0000, 4'hF, 1'b1, {7'h7F, 7'h10, 7'h03, 7'h40}, 4'b1111, {5'd0, 5'd15, 5'd15, 5'd15}};

    // reset state and first frame order
    RST_N = 1'b0;
    drive(16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'hF, 1'b0);
    repeat (3) @(negedge CLK);
    chk("rst_anodes", 32'(bus.anodes), 32'hF);
    chk("rst_segs", 32'(bus.segs), 32'h7F);
    chk("rst_dp", 32'(bus.DP), 32'd1);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
    RST_N = 1'b1;
    for (int d = 0; d < 5; d++) exp_q.push_back({8'(d % N), 8'(2 + 16 * d)});
    prev_an = 4'hF;
    for (int k = 1; k <= 70; k++) begin
      @(negedge CLK);
      if (k == 2) chk("first_digit_shows_0", 32'(bus.segs), 32'h40);
      if (bus.anodes != 4'hF && prev_an == 4'hF) begin
        ldig = 0;
        for (int d = 0; d < N; d++) if (!bus.anodes[d]) ldig = d;
        ev = {8'(ldig), 8'(k)};
        if (exp_q.size() == 0) chk("scan_order_extra", 32'(ev), 32'hFFFF);
        else chk("scan_order", 32'(ev), 32'(exp_q.pop_front()));
      end
      prev_an = bus.anodes;
    end
    chk("scan_order_all_seen", 32'(exp_q.size()), 32'd0);

    // table vectors
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].digits, vecs[v].dec_pts, vecs[v].signs, 4'b0000, vecs[v].bright, vecs[v].lz);
      wait_frame_start($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), vecs[v].exp_segs, vecs[v].exp_dp, vecs[v].exp_lit);
    end

    // mid-frame input change stays hidden until the next snapshot
    drive(16'h12AF, 4'b0001, 4'b0100, 4'b0000, 4'hF, 1'b0);
    wait_frame_start("midchg");
    bus.digits = 16'h3456;
    check_frame("midchg_old", vecs[0].exp_segs, vecs[0].exp_dp, vecs[0].exp_lit);
    check_frame("midchg_new", {7'h30, 7'h3F, 7'h12, 7'h02}, 4'b1110, {5'd15, 5'd15, 5'd15, 5'd15});

    // blink: phase starts on after reset, toggles every 2 frames
    RST_N = 1'b0;
    drive(16'h0000, 4'b0000, 4'b0000, 4'b0010, 4'hF, 1'b0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    wait_frame_start("blink");
    for (int f = 1; f <= 6; f++) begin
      logic on;
      on = ((f / 2) % 2) == 0;
      check_frame($sformatf("blink_f%0d", f), {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111,
                  {5'd15, 5'd15, on ? 5'd15 : 5'd0, 5'd15});
    end

    // asynchronous reset in the middle of slot 2
    drive(16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'hF, 1'b0);
    wait_frame_start("midrst");
    repeat (2 * SD + 5) @(negedge CLK);
    chk("midrst_before", 32'(bus.anodes), 32'hB);
    #3 RST_N = 1'b0;
    #1;
    chk("midrst_anodes", 32'(bus.anodes), 32'hF);
    chk("midrst_segs", 32'(bus.segs), 32'h7F);
    chk("midrst_dp", 32'(bus.DP), 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_guard", 32'(bus.anodes), 32'hF);
    @(negedge CLK);
    chk("midrst_idx0", 32'(bus.anodes), 32'hE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
